// File: rtl/rcu_stage.sv
// Registered worm-locking Z-X-Y route computation stage with lateral backup for faulty vertical links.
// Optional saturating fault statistics (backup_count, drop_count) are built when RCU_FAULT_STATS_EN is defined.
package rcu_header;
  localparam int MESH_WIDTH  = 4;
  localparam int MESH_HEIGHT = 4;
  localparam int MESH_DEPTH  = 4;
  localparam int XW = (MESH_WIDTH  > 1) ? $clog2(MESH_WIDTH)  : 1;
  localparam int YW = (MESH_HEIGHT > 1) ? $clog2(MESH_HEIGHT) : 1;
  localparam int ZW = (MESH_DEPTH  > 1) ? $clog2(MESH_DEPTH)  : 1;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, EAST, WEST, UP, DOWN, DROP} port_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } position_t;
endpackage

module rcu_stage
  import rcu_header::*;
#(
  parameter position_t THIS_POS    = '{x: '0, y: '0, z: '0},
  parameter bit        BACKUP_MODE = 1'b0,
  parameter int        STAT_W      = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  logic      in_head,
  input  logic      in_tail,
  input  port_t     in_inport,
  input  position_t in_dest,
  input  logic      up_faulty,
  input  logic      down_faulty,
  output logic      out_valid,
  input  logic      out_ready,
  output port_t     out_port,
  output logic      out_tail
`ifdef RCU_FAULT_STATS_EN
  ,
  output logic [STAT_W-1:0] backup_count,
  output logic [STAT_W-1:0] drop_count
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam bit AT_WEST  = (int'(THIS_POS.x) == 0);
  localparam bit AT_EAST  = (int'(THIS_POS.x) == MESH_WIDTH - 1);
  localparam bit AT_SOUTH = (int'(THIS_POS.y) == 0);
  localparam bit AT_NORTH = (int'(THIS_POS.y) == MESH_HEIGHT - 1);

  state_t             state;
  port_t              route_q;
  logic [1:0]         rr_ptr;
  logic               accept;
  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic signed [ZW:0] dz;
  logic               fault, rr_found;
  logic [1:0]         rr_sel;
  port_t              dir_port, fixed_bk, rr_bk, head_port, next_port;

  // Round-robin pointer order: 0 EAST, 1 NORTH, 2 WEST, 3 SOUTH
  function automatic port_t rr_port(input logic [1:0] idx);
    case (idx)
      2'd0:    return EAST;
      2'd1:    return NORTH;
      2'd2:    return WEST;
      default: return SOUTH;
    endcase
  endfunction

  function automatic logic on_mesh(input port_t p);
    case (p)
      EAST:    return !AT_EAST;
      NORTH:   return !AT_NORTH;
      WEST:    return !AT_WEST;
      SOUTH:   return !AT_SOUTH;
      default: return 1'b0;
    endcase
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign dx = $signed({1'b0, in_dest.x}) - $signed({1'b0, THIS_POS.x});
  assign dy = $signed({1'b0, in_dest.y}) - $signed({1'b0, THIS_POS.y});
  assign dz = $signed({1'b0, in_dest.z}) - $signed({1'b0, THIS_POS.z});

  always_comb begin
    fault = 1'b0;
    if (dz != '0) begin
      dir_port = dz[ZW] ? DOWN : UP;
      fault    = dz[ZW] ? down_faulty : up_faulty;
    end else if (dx != '0) begin
      dir_port = dx[XW] ? WEST : EAST;
    end else if (dy != '0) begin
      dir_port = dy[YW] ? SOUTH : NORTH;
    end else begin
      dir_port = LOCAL;
    end
  end

  // Edge-aware fixed backup, a function of the inport and this router's position only
  always_comb begin
    fixed_bk = DROP;
    case (in_inport)
      EAST: begin
        if (!AT_WEST)             fixed_bk = WEST;
        else if (MESH_HEIGHT > 1) fixed_bk = AT_NORTH ? SOUTH : NORTH;
      end
      SOUTH:   fixed_bk = AT_NORTH ? SOUTH : NORTH;
      NORTH:   if (!AT_SOUTH) fixed_bk = SOUTH;
      default: begin
        if (MESH_WIDTH > 1)       fixed_bk = AT_EAST ? WEST : EAST;
        else if (MESH_HEIGHT > 1) fixed_bk = AT_NORTH ? SOUTH : NORTH;
      end
    endcase
  end

  always_comb begin
    rr_found = 1'b0;
    rr_sel   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!rr_found && on_mesh(rr_port(rr_ptr + 2'(k))) &&
          (rr_port(rr_ptr + 2'(k)) != in_inport)) begin
        rr_found = 1'b1;
        rr_sel   = rr_ptr + 2'(k);
      end
    end
    rr_bk = rr_found ? rr_port(rr_sel) : DROP;
  end

  always_comb begin
    head_port = dir_port;
    if (fault) head_port = BACKUP_MODE ? rr_bk : fixed_bk;
    if (in_head)               next_port = head_port;
    else if (state == LOCKED)  next_port = route_q;
    else                       next_port = DROP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      route_q   <= LOCAL;
      rr_ptr    <= 2'd0;
      out_valid <= 1'b0;
      out_port  <= LOCAL;
      out_tail  <= 1'b0;
    end else begin
      if (accept)         out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_port <= next_port;
        out_tail <= in_tail;
        if (in_head) begin
          route_q <= head_port;
          state   <= in_tail ? IDLE : LOCKED;
          if (BACKUP_MODE && fault && rr_found) rr_ptr <= rr_sel + 2'd1;
        end else if (in_tail) begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef RCU_FAULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      backup_count <= '0;
      drop_count   <= '0;
    end else begin
      if (accept && in_head && fault && !(&backup_count))
        backup_count <= backup_count + STAT_W'(1);
      if (accept && (next_port == DROP) && !(&drop_count))
        drop_count <= drop_count + STAT_W'(1);
    end
  end
`endif
endmodule

// File: doc/rcu_stage.md
# rcu_stage

Registered, worm-locking route computation stage for one router input port of the 3-D mesh. It accepts flits over a valid/ready handshake and computes a dimension-ordered (Z, then X, then Y) output port for each head flit, substituting a lateral backup port when the required vertical link is faulty. It holds that route for the body and tail flits of the packet and presents the result one cycle later to the switch allocator. It is the pipelined, parametrised successor to the combinational `rcu`, and uses `port_t`, `position_t` and `MESH_WIDTH/HEIGHT/DEPTH` from `rcu_header`.

## Interface
- `THIS_POS`, `'{x:0,y:0,z:0}`: mesh coordinate of this router.
- `BACKUP_MODE`, `0`: backup selection. 0 = fixed edge-aware rule; 1 = round-robin over legal lateral ports.
- `STAT_W`, `16`: width of the statistics counters.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input flit valid.
- `in_ready` out 1: stage can accept a flit.
- `in_head` in 1: flit is a packet head.
- `in_tail` in 1: flit is a packet tail. Head and tail may both be set (single-flit packet).
- `in_inport` in `port_t`: port the flit arrived on.
- `in_dest` in `position_t`: destination, valid on head flits only.
- `up_faulty` in 1: UP link unusable.
- `down_faulty` in 1: DOWN link unusable.
- `out_valid` out 1: routed flit valid.
- `out_ready` in 1: allocator accepts the routed flit.
- `out_port` out `port_t`: output port for this flit.
- `out_tail` out 1: registered copy of `in_tail`.
- `backup_count` out `STAT_W`: present only with `RCU_FAULT_STATS_EN`.
- `drop_count` out `STAT_W`: present only with `RCU_FAULT_STATS_EN`.

## Operation
- **Handshake:** one output register. `in_ready = !out_valid || out_ready`. A flit is accepted when `in_valid && in_ready`.
- **States:**
  - `IDLE`: waiting for a head.
  - `LOCKED`: inside a worm; `route_q` holds the output port.
- **Head accepted, any state:**
  - Compute the route and load it into `route_q` and `out_port`.
  - Go to `LOCKED`, or stay in `IDLE` if `in_tail` is also set.
  - A head arriving in `LOCKED` abandons the old worm and restarts.
- **Non-head accepted in `LOCKED`:** `out_port = route_q`. A tail returns the stage to `IDLE`.
- **Non-head accepted in `IDLE`:** `out_port = DROP`, and the state stays `IDLE`.
- **Route computation:**
  - Take signed hop counts, one bit wider than each coordinate, as `dest - THIS_POS`.
  - If z ≠ 0, route UP/DOWN. If that link's fault bit is set on the accept cycle, use the backup port instead.
  - Otherwise, if x ≠ 0, route EAST/WEST.
  - Otherwise, if y ≠ 0, route NORTH/SOUTH.
  - Otherwise, route LOCAL.
  - Fault bits are sampled only when a head is accepted. Changes mid-worm do not affect the locked route.
- **Fixed backup (mode 0):**
  - Inport EAST: WEST. At the west edge, NORTH, or SOUTH if also at the north edge. DROP if `MESH_HEIGHT==1`.
  - Inport SOUTH: NORTH, or SOUTH at the north edge.
  - Inport NORTH: SOUTH, or DROP at the south edge.
  - Any other inport: EAST, or WEST at the east edge. If `MESH_WIDTH==1`: NORTH, or SOUTH at the north edge. DROP if the mesh is 1×1.
- **Round-robin backup (mode 1):**
  - A 2-bit pointer steps through the order EAST, NORTH, WEST, SOUTH.
  - Select the first port at or after the pointer that is on-mesh and is not `in_inport`.
  - After each use, the pointer advances to one past the selected port.
  - If no port is legal, select DROP and leave the pointer unchanged.

## Timing
- **Latency:** the accept edge produces `out_valid` one cycle later. A stalled output holds `out_port` and `out_tail` stable.
- **Throughput:** one flit per cycle when `out_ready=1`. Simultaneous output consume and input accept is allowed.
- **Reset values:**
  - `out_valid=0`, `out_port=LOCAL`, `out_tail=0`.
  - State `IDLE`, `route_q=LOCAL`, pointer EAST, counters 0, `in_ready=1`.
- **Reset mid-worm:** the worm is forgotten. The next non-head flit goes to DROP.

## Configuration
- **With `RCU_FAULT_STATS_EN` defined:**
  - `backup_count` increments on each head routed via backup.
  - `drop_count` increments on each flit accepted with `out_port=DROP`.
  - Both counters saturate at all-ones and are cleared by reset.
- **Without it:** the counters and both ports are absent. Routing is unchanged.

## Test plan
Mesh 4×4×4 and `THIS_POS=(1,1,1)` unless stated.
- Head, 2 bodies, then tail with `dest=(3,1,1)`, `inport=LOCAL`, `out_ready=1` → `out_port=EAST` on 4 consecutive cycles, with the first one cycle after the head. `out_tail=1` on the last flit, then `IDLE`.
- Mode 0, head `dest=(1,1,3)`, `up_faulty=1`, `inport=WEST` → EAST. `up_faulty` then drops to 0 mid-worm → body flits stay EAST.
- Mode 1, three single-flit packets with `dest z=3`, `up_faulty=1`, `inport=LOCAL` → EAST, NORTH, WEST. Expected `backup_count=3` (with stats enabled).
- `out_ready=0` for 3 cycles with a routed flit pending → `in_ready=0`, `out_port` stable. Release → exactly one transfer per flit, none lost or duplicated.
- Body flit with `in_head=0` in `IDLE` → `out_port=DROP`, `drop_count` goes 0→1.
- Assert `rst_n` after the head of a NORTH worm (`dest=(1,3,1)`) → `out_valid=0` during reset. The following body flit → DROP.
